// File: rtl/spi_slave_responder_if.sv
// Bus bundle for spi_slave_responder: SPI pins plus the tx/rx word handshakes.
// Error-flag signals exist only when SPI_SLAVE_ERR_FLAGS_EN is defined.
interface spi_slave_responder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_ss_n;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic                  err_clr;
  logic                  rx_ack;
  logic                  tx_underrun;
  logic                  rx_overrun;

  modport slave (
    input  spi_sclk, spi_mosi, spi_ss_n, tx_data, tx_valid, err_clr, rx_ack,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy,
           tx_underrun, rx_overrun
  );

  modport master (
    output spi_sclk, spi_mosi, spi_ss_n, tx_data, tx_valid, err_clr, rx_ack,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy,
           tx_underrun, rx_overrun
  );
`else
  modport slave (
    input  spi_sclk, spi_mosi, spi_ss_n, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy
  );

  modport master (
    output spi_sclk, spi_mosi, spi_ss_n, tx_data, tx_valid,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy
  );
`endif
endinterface

// File: rtl/spi_slave_responder.sv
// SPI target that oversamples SCLK/MOSI/SS_N in the clk domain, full duplex, MSB first.
// Optional sticky error flags are enabled with `define SPI_SLAVE_ERR_FLAGS_EN.
module spi_slave_responder #(
  parameter int                    DATA_WIDTH = 8,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '1
) (
  input logic                  clk,
  input logic                  resetn,
  spi_slave_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic sclk_meta, sclk_s, sclk_d;
  logic mosi_meta, mosi_s;
  logic ss_meta, ss_s, ss_d;

  // NOTE: synchronizer flops are deliberately left without reset so that releasing
  // resetn while ss_n is already low cannot fabricate a select falling edge.
  always_ff @(posedge clk) begin
    {sclk_d, sclk_s, sclk_meta} <= {sclk_s, sclk_meta, bus.spi_sclk};
    {mosi_s, mosi_meta}         <= {mosi_meta, bus.spi_mosi};
    {ss_d, ss_s, ss_meta}       <= {ss_s, ss_meta, bus.spi_ss_n};
  end

  logic lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;
  assign lead_edge   = (sclk_d == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_d != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;
  assign ss_fall     = ss_d && !ss_s;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-2:0] rx_sr;
  logic                  fresh;
  logic                  miso_q, miso_oe_q, tx_ready_q, rx_valid_q, busy_q;
  logic [DATA_WIDTH-1:0] rx_data_q;

  logic [DATA_WIDTH-1:0] tx_next, rx_word;
  logic                  word_done, reload, load_now;
  assign tx_next   = bus.tx_valid ? bus.tx_data : FILL_WORD;
  assign rx_word   = {rx_sr, mosi_s};
  assign word_done = (state == SHIFT) && sample_edge && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  // A word that completes on the same clock as ss_n rising is kept, but no new tx word is taken.
  assign reload    = word_done && !ss_s;
  assign load_now  = (state == LOAD) || reload;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      fresh      <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are raised below; later non-blocking
      // assignments in the same block override earlier ones.
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= !ss_s;

      if (load_now) begin
        tx_sr      <= tx_next;
        tx_ready_q <= bus.tx_valid;
      end

      case (state)
        IDLE: begin
          miso_oe_q <= 1'b0;
          if (ss_fall) state <= LOAD;
        end
        LOAD: begin
          bit_cnt   <= '0;
          fresh     <= CPHA;
          if (!CPHA) miso_q <= tx_next[DATA_WIDTH-1];
          miso_oe_q <= !ss_s;
          state     <= ss_s ? IDLE : SHIFT;
        end
        SHIFT: begin
          miso_oe_q <= 1'b1;
          if (sample_edge) begin
            rx_sr   <= rx_word[DATA_WIDTH-2:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (word_done) begin
              rx_data_q  <= rx_word;
              rx_valid_q <= 1'b1;
              bit_cnt    <= '0;
              fresh      <= 1'b1;
            end
          end else if (shift_edge) begin
            // The first shift edge after a load presents the MSB instead of shifting past it.
            if (fresh) begin
              miso_q <= tx_sr[DATA_WIDTH-1];
              fresh  <= 1'b0;
            end else begin
              tx_sr  <= tx_sr << 1;
              miso_q <= tx_sr[DATA_WIDTH-2];
            end
          end
          if (ss_s) begin
            state     <= IDLE;
            miso_oe_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = miso_oe_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = busy_q;

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic tx_underrun_q, rx_overrun_q, rx_pending;
  logic underrun_set, overrun_set;
  assign underrun_set = load_now && !bus.tx_valid;
  assign overrun_set  = rx_valid_q && rx_pending;

  // rx_pending marks a delivered word not yet acknowledged; an ack alongside rx_valid covers the new word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      rx_pending    <= 1'b0;
    end else begin
      tx_underrun_q <= underrun_set || (tx_underrun_q && !bus.err_clr);
      rx_overrun_q  <= overrun_set  || (rx_overrun_q  && !bus.err_clr);
      if (rx_valid_q)      rx_pending <= !bus.rx_ack;
      else if (bus.rx_ack) rx_pending <= 1'b0;
    end
  end

  assign bus.tx_underrun = tx_underrun_q;
  assign bus.rx_overrun  = rx_overrun_q;
`endif

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI target (responder) that forms the far end of the SoC's SPI master port (spi0_clk/spi0_mosi/spi0_miso/spi0_ss_n).
- Used as a bench model and as an on-chip peripheral endpoint.
- Oversamples SCLK, MOSI and SS_N in the system clock domain, shifts received words out on a valid pulse, and serves transmit words through a valid/ready handshake.
- Full duplex, MSB first, with SPI mode chosen by parameters.

Parameters:
- DATA_WIDTH, 8: bits per SPI word.
- CPOL, 0: SCLK idle level.
- CPHA, 0:
  - 0 = sample on the leading edge, shift on the trailing edge.
  - 1 = shift on the leading edge, sample on the trailing edge.
- FILL_WORD, all ones (8'hFF): word transmitted when no tx word is offered at a word boundary.

Ports:
- clk  input  1  system clock; must be at least 4x the SCLK frequency.
- resetn  input  1  synchronous active-low reset.
- spi_sclk  input  1  SPI clock from the master; asynchronous.
- spi_mosi  input  1  master-out data; asynchronous.
- spi_ss_n  input  1  active-low select; asynchronous.
- spi_miso  output  1  target-out data.
- spi_miso_oe  output  1  MISO drive enable for the top-level tristate.
- tx_data  input  DATA_WIDTH  next word to transmit.
- tx_valid  input  1  tx_data is offered.
- tx_ready  output  1  one-cycle pulse when tx_data is captured.
- rx_data  output  DATA_WIDTH  last complete received word.
- rx_valid  output  1  one-cycle pulse when a word completes.
- busy  output  1  transaction active (synchronized ss_n low).

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - Synchronous active-low reset `resetn`, sampled on the rising edge of clk.
- Synchronization and edge detection:
  - spi_sclk, spi_mosi and spi_ss_n each pass through a 2-FF synchronizer.
  - A third register on sclk provides edge detection.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading edge if CPHA=0, else trailing edge. Shift edge = the other edge.
- Reset values: spi_miso=0, spi_miso_oe=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0. The FSM enters IDLE and the bit counter resets to 0.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE:
  - spi_miso_oe=0.
  - On a synced ss_n falling edge, go to LOAD.
- LOAD (one cycle):
  - If tx_valid=1: shift register <= tx_data and tx_ready pulses in this cycle.
  - Otherwise: shift register <= FILL_WORD and no pulse.
  - Bit counter <= 0.
  - If CPHA=0, spi_miso <= MSB now.
  - Go to SHIFT.
- SHIFT:
  - spi_miso_oe=1.
  - On each sample edge: rx shift register <= {rx[DATA_WIDTH-2:0], mosi_sync}; bit counter increments.
  - On each shift edge: the tx register shifts left and spi_miso <= the new MSB. With CPHA=1, the first leading edge drives the MSB without shifting.
- Word completion (bit counter reaches DATA_WIDTH on a sample edge):
  - Next cycle: rx_data <= assembled word and rx_valid pulses for 1 clk.
  - The counter wraps to 0.
  - The next tx word is captured as in LOAD, with tx_ready pulsing in that same cycle. For CPHA=0 its MSB is driven at the following trailing edge.
- Back-to-back words under continuous ss_n low are supported with no SCLK gap.
- ss_n rise at any point (synced):
  - Return to IDLE and set spi_miso_oe=0.
  - A partial word is discarded: no rx_valid, and rx_data is unchanged.
  - A tx word already captured is consumed, not replayed.
- Simultaneous ss_n rise and sample edge: ss_n wins and the word is discarded unless that edge was the final bit.
- busy mirrors synced ss_n low.
- Latency: rx_valid occurs 3-4 clk after the last SCLK sample edge at the pins.
- Reset asserted mid-transaction: all state returns to reset values on that clock. The transaction resumes only at the next ss_n falling edge.

Optional Feature:
- Macro: SPI_SLAVE_ERR_FLAGS_EN.
- When defined, the block adds:
  - Input err_clr.
  - Output tx_underrun: sticky; set when FILL_WORD is loaded because tx_valid=0.
  - Output rx_overrun: sticky; set when rx_valid fires while input rx_ack has not been seen since the previous rx_valid.
  - Input rx_ack.
- Both flags clear on err_clr=1 or reset. A set event in the same cycle as err_clr wins.
- When not defined: no ports or logic for err_clr, rx_ack, tx_underrun or rx_overrun.

Test Plan:
- Mode 0, SCLK = clk/8, tx_data=8'hA5 held valid, master sends 8'h3C:
  - tx_ready pulses once.
  - MISO bit stream is 1,0,1,0,0,1,0,1.
  - rx_valid pulses once with rx_data=8'h3C.
- Mode 0, 3 back-to-back words 8'h01, 8'h80, 8'hFF with a tx source supplying 8'h11, 8'h22, 8'h33:
  - 3 rx_valid pulses in order and 3 tx_ready pulses.
  - Master receives 11/22/33 with no gap.
- tx_valid=0 throughout: master receives 8'hFF. With the macro, tx_underrun=1 until err_clr.
- ss_n raised after 5 SCLK cycles: no rx_valid, rx_data keeps its prior value, miso_oe drops within 3 clk.
- Rerun the first scenario with CPOL=1/CPHA=1 using 8'hC3 / 8'h5A: master receives 8'hC3 and rx_data=8'h5A.
- resetn low for 1 clk mid-word, then a fresh transaction with 8'h7E: all outputs are at reset values after the reset cycle and the new word is received correctly.
